// File: rtl/serial_magnitude_comparator.sv
// Serial unsigned magnitude comparator: walks two WIDTH-bit operands MSB-first, 2 bits per clock.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as the first unequal slice is seen.

module two_bit_comparator (
   input  logic [1:0] a,
   input  logic [1:0] b,
   output logic       gt,
   output logic       lt,
   output logic       eq
);
   always_comb begin
      gt = (a[1] & ~b[1]) | (~(a[1] ^ b[1]) & a[0] & ~b[0]);
      lt = (~a[1] & b[1]) | (~(a[1] ^ b[1]) & ~a[0] & b[0]);
      eq = (a == b);
   end
endmodule

module serial_magnitude_comparator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             a_gt_b,
   output logic             a_lt_b,
   output logic             a_eq_b
);
   localparam int N  = WIDTH / 2;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d;
   logic [WIDTH-1:0] sb_q, sb_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             decided_q, decided_d;
   logic             pend_gt_q, pend_gt_d;
   logic             pend_lt_q, pend_lt_d;
   logic             done_q, done_d;
   logic             gt_q, gt_d;
   logic             lt_q, lt_d;
   logic             eq_q, eq_d;

   logic             slice_gt, slice_lt, slice_eq;
   logic             fin_gt, fin_lt;
   logic             finish;

   two_bit_comparator u_slice (
      .a  (sa_q[WIDTH-1:WIDTH-2]),
      .b  (sb_q[WIDTH-1:WIDTH-2]),
      .gt (slice_gt),
      .lt (slice_lt),
      .eq (slice_eq)
   );

   // Once a slice has decided, the earlier verdict wins over everything below it.
   always_comb begin
      fin_gt = decided_q ? pend_gt_q : slice_gt;
      fin_lt = decided_q ? pend_lt_q : slice_lt;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      finish = (cnt_q == '0) | ~slice_eq;
`else
      finish = (cnt_q == '0);
`endif
   end

   always_comb begin
      state_d   = state_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      cnt_d     = cnt_q;
      decided_d = decided_q;
      pend_gt_d = pend_gt_q;
      pend_lt_d = pend_lt_q;
      done_d    = 1'b0;
      gt_d      = gt_q;
      lt_d      = lt_q;
      eq_d      = eq_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               sa_d      = a;
               sb_d      = b;
               cnt_d     = CW'(N - 1);
               decided_d = 1'b0;
               pend_gt_d = 1'b0;
               pend_lt_d = 1'b0;
               state_d   = S_RUN;
            end
         end
         S_RUN: begin
            sa_d      = {sa_q[WIDTH-3:0], 2'b00};
            sb_d      = {sb_q[WIDTH-3:0], 2'b00};
            cnt_d     = cnt_q - 1'b1;
            decided_d = decided_q | ~slice_eq;
            pend_gt_d = fin_gt;
            pend_lt_d = fin_lt;
            // Outputs are loaded on the way into DONE so they are valid alongside the done pulse.
            if (finish) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               gt_d    = fin_gt;
               lt_d    = fin_lt;
               eq_d    = ~fin_gt & ~fin_lt;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sa_q      <= '0;
         sb_q      <= '0;
         cnt_q     <= '0;
         decided_q <= 1'b0;
         pend_gt_q <= 1'b0;
         pend_lt_q <= 1'b0;
         done_q    <= 1'b0;
         gt_q      <= 1'b0;
         lt_q      <= 1'b0;
         eq_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         sa_q      <= sa_d;
         sb_q      <= sb_d;
         cnt_q     <= cnt_d;
         decided_q <= decided_d;
         pend_gt_q <= pend_gt_d;
         pend_lt_q <= pend_lt_d;
         done_q    <= done_d;
         gt_q      <= gt_d;
         lt_q      <= lt_d;
         eq_q      <= eq_d;
      end
   end

   assign busy   = (state_q == S_RUN);
   assign done   = done_q;
   assign a_gt_b = gt_q;
   assign a_lt_b = lt_q;
   assign a_eq_b = eq_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator (WIDTH=8); expected latencies follow
// SERIAL_CMP_EARLY_EXIT_EN when it is defined for the build.

module tb_serial_magnitude_comparator;
   localparam int WIDTH = 8;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
   localparam int LAT_80_7F = 1;
   localparam int LAT_40_30 = 1;
`else
   localparam int LAT_80_7F = 4;
   localparam int LAT_40_30 = 4;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             busy, done, a_gt_b, a_lt_b, a_eq_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int busy_tot = 0;

   typedef struct packed {
      logic [2:0]  res;
      logic [31:0] t;
   } exp_t;
   exp_t sb[$];

   serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .a_gt_b (a_gt_b),
      .a_lt_b (a_lt_b),
      .a_eq_b (a_eq_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: pops an expectation on every done pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (busy) busy_tot++;
            checks++;
            if ($countones({a_gt_b, a_lt_b, a_eq_b}) != 1) begin
               errors++;
               $display("FAIL onehot cyc=%0d got %b want one-hot", cyc, {a_gt_b, a_lt_b, a_eq_b});
            end
            if (done) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_done cyc=%0d got done=1 want 0", cyc);
               end else begin
                  e = sb.pop_front();
                  checks++;
                  if ({a_gt_b, a_lt_b, a_eq_b} != e.res) begin
                     errors++;
                     $display("FAIL result cyc=%0d got gt/lt/eq=%b want %b", cyc, {a_gt_b, a_lt_b, a_eq_b}, e.res);
                  end
                  checks++;
                  if (cyc != int'(e.t)) begin
                     errors++;
                     $display("FAIL done_time got cyc=%0d want %0d", cyc, e.t);
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic issue(input logic [7:0] va, input logic [7:0] vb,
                        input logic [2:0] res, input int lat);
      int acc;
      @(posedge clk); #1;
      a = va; b = vb; start = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      start = 1'b0;
      sb.push_back('{res: res, t: 32'(acc + lat)});
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout got pending=%0d want 0", name, sb.size());
         sb.delete();
      end
      repeat (2) @(posedge clk);
   endtask

   initial begin
      int b0;
      int acc;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_res", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'b001);
      rst_n = 1'b1;

      // Equal operands, full walk, busy for exactly N cycles
      b0 = busy_tot;
      issue(8'hA5, 8'hA5, 3'b001, 4);
      drain("eq");
      chk("eq_busy_cycles", 32'(busy_tot - b0), 4);

      // Greater, decided at the first slice
      issue(8'h80, 8'h7F, 3'b100, LAT_80_7F);
      drain("gt");

      // Less, decided only at the last slice
      issue(8'h12, 8'h13, 3'b010, 4);
      drain("lt");
      chk("lt_hold", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'b010);

      // Second start while running must be ignored; new inputs must not matter
      @(posedge clk); #1;
      a = 8'h40; b = 8'h30; start = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      sb.push_back('{res: 3'b100, t: 32'(acc + LAT_40_30)});
      a = 8'h00; b = 8'hFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      drain("ignore");
      repeat (8) @(posedge clk);
      #1;
      chk("ignore_hold", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'b100);

      // Reset two cycles into a run
      @(posedge clk); #1;
      a = 8'h12; b = 8'h13; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_res", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'b001);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      issue(8'h12, 8'h13, 3'b010, 4);
      drain("after_rst");

      // Back-to-back with start held high
      @(posedge clk); #1;
      a = 8'h01; b = 8'h02; start = 1'b1;
      @(posedge clk); #1;
      acc = cyc;
      sb.push_back('{res: 3'b010, t: 32'(acc + 4)});
      sb.push_back('{res: 3'b010, t: 32'(acc + 10)});
      sb.push_back('{res: 3'b010, t: 32'(acc + 16)});
      repeat (16) @(posedge clk);
      #1;
      start = 1'b0;
      drain("b2b");
      repeat (8) @(posedge clk);
      #1;
      chk("b2b_hold", 32'({a_gt_b, a_lt_b, a_eq_b}), 32'b010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Sequential WIDTH-bit unsigned magnitude comparator built around one `two_bit_comparator` slice, sitting directly downstream of it. Captures two operands on a start strobe, then walks them MSB-first, 2 bits per clock, through the slice and accumulates its gt/lt/eq outputs into a final one-hot result. Trades latency for area on the Elbert V2 (Spartan-3), with a start/busy/done handshake.

## Interface
- `WIDTH`, 8, operand width in bits; even, ≥ 4; N = WIDTH/2 slices
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only in IDLE
- `a`  in  WIDTH  operand A, unsigned, captured on accepted start
- `b`  in  WIDTH  operand B, unsigned, captured on accepted start
- `busy`  out  1  high while slices are being processed
- `done`  out  1  one-cycle pulse, result valid
- `a_gt_b`  out  1  registered result, A > B
- `a_lt_b`  out  1  registered result, A < B
- `a_eq_b`  out  1  registered result, A = B

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 loads `a` and `b` into shift registers `sa` and `sb`, loads slice counter with N-1, clears the decided flag, then goes to RUN.
- RUN: the slice compares `sa[WIDTH-1:WIDTH-2]` against `sb[WIDTH-1:WIDTH-2]`.
  - Each cycle, `sa` and `sb` shift left by 2 with zero fill and the counter decrements.
  - The first unequal slice sets the decided flag and latches gt or lt into a pending result.
  - Later slices never override a decided result.
  - After the slice at counter=0 is processed, go to DONE. If nothing was decided, the pending result is eq.
- DONE: outputs load the pending result, `done`=1, then go to IDLE unconditionally.
- `start` is ignored in RUN and DONE. There is no queueing.
- Input changes after capture have no effect.
- `a_gt_b`, `a_lt_b` and `a_eq_b` are always exactly one-hot. They hold the last result until the next DONE, and are unchanged during RUN.
- Reset values: `busy`=0, `done`=0, `a_gt_b`=0, `a_lt_b`=0, `a_eq_b`=1. State is IDLE and the shift registers and counter are 0.
- Reset mid-RUN or mid-DONE: immediate return to reset values, no `done` pulse, the in-flight result is discarded.

## Timing
- Edge E0 accepts `start`. The slice for counter value k is processed at edge E(N-k).
- Full walk: the last slice is processed at EN. The outputs and `done` are valid in the cycle after EN, and the state returns to IDLE at EN+1.
- `busy` is high from after E0 until EN, and low in the DONE cycle.
- Start-to-done latency is N cycles. With `start` held high, back-to-back requests are accepted every N+2 cycles.
- The slice is purely combinational on the top bits of the shift registers. There are no other combinational paths from inputs to outputs.

## Configuration
- `SERIAL_CMP_EARLY_EXIT_EN` defined: an unequal slice processed at edge Ej moves RUN straight to DONE at Ej. Result and `done` follow one cycle later, so latency is j cycles. Equal operands still take N cycles.
- Undefined: always N cycles regardless of data. Timing is data-independent.
- The result values are identical in both builds.

## Test plan
- WIDTH=8, a=0xA5, b=0xA5, start pulse → `done` 4 cycles after accept; eq=1, gt=0, lt=0; `busy` high for exactly 4 cycles.
- a=0x80, b=0x7F → gt=1. With EARLY_EXIT, `done` comes 1 cycle after accept; without it, 4 cycles.
- a=0x12, b=0x13 → lt=1, `done` at 4 cycles in both builds. Result must not flip because of the equal upper slices.
- Accept a=0x40, b=0x30. One cycle later pulse `start` with a=0x00, b=0xFF → second request ignored; result gt=1 with a single `done` pulse.
- Assert `rst_n`=0 two cycles into a run → `busy`=0, `done`=0 and eq=1 immediately; no `done` pulse; a fresh start afterwards completes normally.
- Hold `start`=1 with a fixed pair, a=0x01, b=0x02 → `done` pulses every 6 cycles, lt=1 stable throughout.
